// File: rtl/wavefront_pkg.sv
// Shared constants and helpers for the wavefront skew/deskew buffer.
// Build option: define WAVEFRONT_ZERO_FILL_EN to zero the output data of invalid lanes.
package wavefront_pkg;

    localparam int MODE_SKEW   = 0;
    localparam int MODE_DESKEW = 1;

    // Extra delay of lane k (beyond the common output register).
    // Skew grows with the lane index; deskew mirrors it.
    function automatic int lane_delay(input int k, input int num_lanes,
                                      input int step, input int mode);
        if (mode == MODE_DESKEW) begin
            return (num_lanes - 1 - k) * step;
        end
        return k * step;
    endfunction

    // Bit position of lane k inside a packed lane bus.
    function automatic int lane_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/wavefront_skew_lane.sv
// Single-lane {valid,data} shift register of DEPTH stages; DEPTH=0 is a wire.
// any_valid reports whether any stage of this lane holds a valid token.
module skew_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  any_valid
);

    if (DEPTH == 0) begin : g_pass
        // No storage in this lane, so the control inputs are not needed.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, en, clr};
        assign out_valid   = in_valid;
        assign out_data    = in_data;
        assign any_valid   = 1'b0;
    end else begin : g_pipe
        logic [DEPTH-1:0]                 valid_q, valid_d;
        logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;

        // Shift one stage per enabled cycle; flush drops valid bits only.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (clr) begin
                valid_d = '0;
            end else if (en) begin
                valid_d[0] = in_valid;
                data_d[0]  = in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    valid_d[i] = valid_q[i-1];
                    data_d[i]  = data_q[i-1];
                end
            end
        end

        // Stage registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign out_valid = valid_q[DEPTH-1];
        assign out_data  = data_q[DEPTH-1];
        assign any_valid = |valid_q;
    end

endmodule

// File: rtl/wavefront_skew.sv
// N-lane wavefront skew (MODE 0) / deskew (MODE 1) buffer with stall, flush
// and drain status. Lane latency is 1 + lane_delay() enabled cycles.
// Build option: WAVEFRONT_ZERO_FILL_EN forces out_data of invalid lanes to 0.
module wavefront_skew
    import wavefront_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 5,
    parameter int STEP       = 4,
    parameter int MODE       = MODE_SKEW
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            clr,
    input  logic                            in_valid,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    output logic [NUM_LANES-1:0]            out_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic                            busy,
    output logic                            done
);

    logic [NUM_LANES-1:0]            lane_valid;
    logic [NUM_LANES-1:0]            lane_any;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0]            out_valid_q, out_valid_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                            done_q, done_d;
    logic                            busy_nxt;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam int LSB = lane_lsb(k, DATA_WIDTH);
        skew_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (lane_delay(k, NUM_LANES, STEP, MODE))
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clr      (clr),
            .in_valid (in_valid),
            .in_data  (in_data[LSB +: DATA_WIDTH]),
            .out_valid(lane_valid[k]),
            .out_data (lane_data[LSB +: DATA_WIDTH]),
            .any_valid(lane_any[k])
        );
    end

    assign busy = (|lane_any) | (|out_valid_q);

    // Output register, busy look-ahead and drain pulse. Every token held in a
    // stage moves to a stage or the output register on an enabled cycle, so
    // next-cycle busy is the incoming valid OR any stage valid.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_nxt    = busy;
        if (clr) begin
            out_valid_d = '0;
            busy_nxt    = 1'b0;
        end else if (en) begin
            out_valid_d = lane_valid;
            out_data_d  = lane_data;
            busy_nxt    = in_valid | (|lane_any);
        end
        done_d = busy & ~busy_nxt;
    end

    // Output and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign done      = done_q;

`ifdef WAVEFRONT_ZERO_FILL_EN
    // Present zero bubbles to the PE array on invalid lanes.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (out_valid_q[k]) begin
                out_data[k*DATA_WIDTH +: DATA_WIDTH] = out_data_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
`else
    assign out_data = out_data_q;
`endif

endmodule

// File: tb/tb_wavefront_skew.sv
// Bench for wavefront_skew: three instances (skew, deskew, STEP=0) share the
// stimulus; expected lane outputs are queued with their due enable-cycle and a
// negedge monitor pops and compares them.
module tb_wavefront_skew;

    localparam int W  = 8;
    localparam int N  = 5;
    localparam int NI = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           clr;
    logic           in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   ov   [NI];
    logic [N*W-1:0] od   [NI];
    logic           busy [NI];
    logic           done [NI];

    // Hand-derived lane latencies: skew 1+4k, deskew 1+4(4-k), STEP=0 all 1.
    int lat_tbl [NI][N] = '{'{1, 5, 9, 13, 17}, '{17, 13, 9, 5, 1}, '{1, 1, 1, 1, 1}};

    // {due_tick[31:0], data[7:0]}
    logic [39:0] exp_q [NI][N][$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ticks = 0;
    logic        adv   = 1'b0;

    always #5 clk = ~clk;

    wavefront_skew #(.DATA_WIDTH(W), .NUM_LANES(N), .STEP(4), .MODE(0)) dut_skew (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[0]), .out_data(od[0]), .busy(busy[0]), .done(done[0]));

    wavefront_skew #(.DATA_WIDTH(W), .NUM_LANES(N), .STEP(4), .MODE(1)) dut_deskew (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[1]), .out_data(od[1]), .busy(busy[1]), .done(done[1]));

    wavefront_skew #(.DATA_WIDTH(W), .NUM_LANES(N), .STEP(0), .MODE(0)) dut_flat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[2]), .out_data(od[2]), .busy(busy[2]), .done(done[2]));

    task automatic chk(input string name, input int inst, input int lane,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d lane%0d: got %0h expected %0h", name, inst, lane, act, exp);
        end
    endtask

    // Count enabled edges; the monitor only consumes outputs after such an edge.
    always @(posedge clk) begin
        adv = en && !rst;
        if (adv) ticks++;
    end

    // Monitor: pop and compare every newly presented valid lane output.
    always @(negedge clk) begin
        for (int d = 0; d < NI; d++) begin
            for (int k = 0; k < N; k++) begin
                logic [W-1:0] act;
                logic [39:0]  e;
                act = od[d][k*W +: W];
                if (adv && !rst && ov[d][k]) begin
                    if (exp_q[d][k].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected inst%0d lane%0d: got data %0h expected no output", d, k, act);
                    end else begin
                        e = exp_q[d][k].pop_front();
                        chk("data", d, k, 64'(act), 64'(e[7:0]));
                        chk("tick", d, k, 64'(ticks), 64'(e[39:8]));
                    end
                end
`ifdef WAVEFRONT_ZERO_FILL_EN
                if (!ov[d][k]) chk("zero_fill", d, k, 64'(act), 64'd0);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_exp();
        for (int d = 0; d < NI; d++)
            for (int k = 0; k < N; k++)
                exp_q[d][k].delete();
    endtask

    // One enabled cycle; a valid sample is lane k = i + 0x20*k.
    task automatic drive(input logic v, input int i);
        logic [W-1:0] dat;
        en       = 1'b1;
        clr      = 1'b0;
        in_valid = v;
        for (int k = 0; k < N; k++) begin
            dat = v ? W'(i + 'h20 * k) : '0;
            in_data[k*W +: W] = dat;
            if (v)
                for (int d = 0; d < NI; d++)
                    exp_q[d][k].push_back({32'(ticks + lat_tbl[d][k]), dat});
        end
        step();
    endtask

    task automatic stall(input int n);
        en       = 1'b0;
        in_valid = 1'b1;
        in_data  = '1;
        repeat (n) step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0);
    endtask

    task automatic chk_quiet(input string name);
        for (int d = 0; d < NI; d++) begin
            chk({name, "_valid"}, d, 0, 64'(ov[d]), 64'd0);
            chk({name, "_data"}, d, 0, 64'(od[d]), 64'd0);
            chk({name, "_busy"}, d, 0, 64'(busy[d]), 64'd0);
            chk({name, "_done"}, d, 0, 64'(done[d]), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_quiet("reset");

        // Full stream, continuously enabled.
        for (int i = 0; i < 30; i++) drive(1'b1, i);
        idle(22);

        // Same stream with a 5-cycle stall before sample 10.
        for (int i = 0; i < 30; i++) begin
            if (i == 10) stall(5);
            drive(1'b1, i);
        end
        idle(22);

        // Three samples then idle: busy through cycle 19, done in cycle 20.
        for (int n = 1; n <= 22; n++) begin
            drive(n <= 3, n - 1);
            chk("busy_drain", 0, n, 64'(busy[0]), 64'(n <= 19));
            chk("done_drain", 0, n, 64'(done[0]), 64'(n == 20));
            chk("busy_drain", 1, n, 64'(busy[1]), 64'(n <= 19));
            chk("done_drain", 1, n, 64'(done[1]), 64'(n == 20));
            chk("busy_drain", 2, n, 64'(busy[2]), 64'(n <= 3));
            chk("done_drain", 2, n, 64'(done[2]), 64'(n == 4));
        end
        idle(3);

        // Flush mid-stream; the sample in the flush cycle is dropped.
        for (int i = 0; i < 8; i++) drive(1'b1, i);
        en = 1'b1; clr = 1'b1; in_valid = 1'b1; in_data = '1;
        step();
        flush_exp();
        clr = 1'b0;
        for (int d = 0; d < NI; d++) begin
            chk("clr_valid", d, 0, 64'(ov[d]), 64'd0);
            chk("clr_busy", d, 0, 64'(busy[d]), 64'd0);
            chk("clr_done", d, 0, 64'(done[d]), 64'd1);
        end
        drive(1'b1, 10);
        for (int d = 0; d < NI; d++) chk("clr_done_once", d, 0, 64'(done[d]), 64'd0);
        for (int i = 11; i < 16; i++) drive(1'b1, i);
        idle(22);

        // Asynchronous reset between edges mid-stream.
        for (int i = 0; i < 8; i++) drive(1'b1, i);
        #3 rst = 1'b1;
        #1 chk_quiet("async_rst");
        flush_exp();
        step();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 0);
            for (int d = 0; d < NI; d++) chk("rst_no_done", d, n, 64'(done[d]), 64'd0);
        end

        for (int d = 0; d < NI; d++)
            for (int k = 0; k < N; k++)
                chk("leftover", d, k, 64'(exp_q[d][k].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
